// File: rtl/wb_stage_buffered_pkg.sv
// rtl/wb_stage_buffered_pkg.sv - shared widths and load-size encodings for the writeback stage
package wb_stage_buffered_pkg;

  localparam int WORD_WIDTH           = 32;
  localparam int REG_FILE_ADDRESS_LEN = 4;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

endpackage

// File: rtl/wb_stage_buffered_load_extract.sv
// rtl/wb_stage_buffered_load_extract.sv - byte/half/word lane select with sign or zero extension
module load_extract #(
  parameter int WORD_WIDTH = wb_stage_buffered_pkg::WORD_WIDTH
) (
  input  logic [WORD_WIDTH-1:0] mem_data,
  input  logic [1:0]            load_size,
  input  logic                  load_signed,
  input  logic [1:0]            byte_off,
  output logic [WORD_WIDTH-1:0] result
);
  import wb_stage_buffered_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // byte_off[0] is deliberately ignored for halfword lanes
  always_comb begin
    byte_v = mem_data[{byte_off, 3'b000} +: 8];
    half_v = mem_data[{byte_off[1], 4'b0000} +: 16];
    case (load_size)
      LS_BYTE: result = load_signed ? {{(WORD_WIDTH-8){byte_v[7]}}, byte_v}
                                    : {{(WORD_WIDTH-8){1'b0}}, byte_v};
      LS_HALF: result = load_signed ? {{(WORD_WIDTH-16){half_v[15]}}, half_v}
                                    : {{(WORD_WIDTH-16){1'b0}}, half_v};
      LS_WORD: result = mem_data;
      default: result = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_stage_buffered.sv
// rtl/wb_stage_buffered.sv - in-order writeback buffer; loads wait for memory data, one registered write per retire
module wb_stage_buffered #(
  parameter int WORD_WIDTH   = wb_stage_buffered_pkg::WORD_WIDTH,
  parameter int REG_ADDR_LEN = wb_stage_buffered_pkg::REG_FILE_ADDRESS_LEN,
  parameter int DEPTH        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_ADDR_LEN-1:0] dst,
  input  logic [WORD_WIDTH-1:0]   ALU_res,
  input  logic                    WB_en,
  input  logic                    mem_read,
  input  logic [1:0]              load_size,
  input  logic                    load_signed,
  input  logic [1:0]              byte_off,
  input  logic [WORD_WIDTH-1:0]   mem_data,
  input  logic                    mem_data_valid,
  output logic [REG_ADDR_LEN-1:0] WB_dst,
  output logic                    WB_en_out,
  output logic [WORD_WIDTH-1:0]   WB_value,
  output logic                    wb_busy,
  output logic                    proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [REG_ADDR_LEN-1:0] dst_q       [DEPTH];
  logic [WORD_WIDTH-1:0]   alu_q       [DEPTH];
  logic                    wb_en_q     [DEPTH];
  logic                    mem_read_q  [DEPTH];
  logic [1:0]              size_q      [DEPTH];
  logic                    signed_q    [DEPTH];
  logic [1:0]              off_q       [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic                  head_valid;
  logic                  head_is_load;
  logic                  push;
  logic                  retire;
  logic                  stray_data;
  logic [WORD_WIDTH-1:0] load_value;

  assign in_ready     = (count != FULL_COUNT);
  assign wb_busy      = (count != '0);
  assign head_valid   = wb_busy;
  assign head_is_load = mem_read_q[rd_ptr];
  assign push         = in_valid && in_ready;
  assign retire       = head_valid && (!head_is_load || mem_data_valid);
  // Memory data is only meaningful when a load sits at the head
  assign stray_data   = mem_data_valid && !(head_valid && head_is_load);

  load_extract #(.WORD_WIDTH(WORD_WIDTH)) u_load_extract (
    .mem_data    (mem_data),
    .load_size   (size_q[rd_ptr]),
    .load_signed (signed_q[rd_ptr]),
    .byte_off    (off_q[rd_ptr]),
    .result      (load_value)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      dst_q[wr_ptr]      <= dst;
      alu_q[wr_ptr]      <= ALU_res;
      wb_en_q[wr_ptr]    <= WB_en;
      mem_read_q[wr_ptr] <= mem_read;
      size_q[wr_ptr]     <= load_size;
      signed_q[wr_ptr]   <= load_signed;
      off_q[wr_ptr]      <= byte_off;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (retire)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, retire})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_dst    <= '0;
      WB_en_out <= 1'b0;
      WB_value  <= '0;
      proto_err <= 1'b0;
    end else begin
      WB_en_out <= retire && wb_en_q[rd_ptr];
      if (retire) begin
        WB_dst   <= dst_q[rd_ptr];
        WB_value <= mem_read_q[rd_ptr] ? load_value : alu_q[rd_ptr];
      end
      if (stray_data)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage_buffered.sv
// tb/tb_wb_stage_buffered.sv - vector table plus scoreboard bench for wb_stage_buffered
module tb_wb_stage_buffered;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  dst;
  logic [31:0] ALU_res;
  logic        WB_en;
  logic        mem_read;
  logic [1:0]  load_size;
  logic        load_signed;
  logic [1:0]  byte_off;
  logic [31:0] mem_data;
  logic        mem_data_valid;
  logic [3:0]  WB_dst;
  logic        WB_en_out;
  logic [31:0] WB_value;
  logic        wb_busy;
  logic        proto_err;

  always #5 clk = ~clk;

  wb_stage_buffered #(.WORD_WIDTH(32), .REG_ADDR_LEN(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dst(dst), .ALU_res(ALU_res), .WB_en(WB_en), .mem_read(mem_read),
    .load_size(load_size), .load_signed(load_signed), .byte_off(byte_off),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .WB_dst(WB_dst), .WB_en_out(WB_en_out), .WB_value(WB_value),
    .wb_busy(wb_busy), .proto_err(proto_err)
  );

  typedef struct {
    logic [3:0]  dst;
    logic [31:0] val;
  } sb_t;

  typedef struct {
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vecs[12];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   n_writes  = 0;
  int   w0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Every register-file write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && WB_en_out) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_write", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_dst", WB_dst, mon_e.dst);
        check("sb_value", WB_value, mon_e.val);
      end
    end
  end

  task automatic push(input logic [3:0] d, input logic [31:0] alu, input logic en,
                      input logic mr, input logic [1:0] sz, input logic sg,
                      input logic [1:0] off, input logic [31:0] expv);
    int waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      check("push_timeout", in_ready, 1);
      return;
    end
    dst = d; ALU_res = alu; WB_en = en; mem_read = mr;
    load_size = sz; load_signed = sg; byte_off = off;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (en) sb_q.push_back('{d, expv});
  endtask

  task automatic mem_pulse(input logic [31:0] data);
    mem_data = data;
    mem_data_valid = 1'b1;
    @(posedge clk); #1;
    mem_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    mem_data_valid = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 1'b1, 2'd2, 32'h1280_3456, 32'hFFFF_FF80};
    vecs[1]  = '{2'b01, 1'b0, 2'd2, 32'h1280_3456, 32'h0000_1280};
    vecs[2]  = '{2'b00, 1'b0, 2'd2, 32'h1280_3456, 32'h0000_0080};
    vecs[3]  = '{2'b00, 1'b1, 2'd0, 32'h1280_3456, 32'h0000_0056};
    vecs[4]  = '{2'b00, 1'b1, 2'd1, 32'h1280_3456, 32'h0000_0034};
    vecs[5]  = '{2'b01, 1'b1, 2'd0, 32'h1280_3456, 32'h0000_3456};
    vecs[6]  = '{2'b01, 1'b1, 2'd3, 32'h1280_3456, 32'h0000_1280};
    vecs[7]  = '{2'b10, 1'b1, 2'd1, 32'h1280_3456, 32'h1280_3456};
    vecs[8]  = '{2'b11, 1'b0, 2'd0, 32'h1280_3456, 32'h1280_3456};
    vecs[9]  = '{2'b00, 1'b1, 2'd3, 32'hDEAD_BEEF, 32'hFFFF_FFDE};
    vecs[10] = '{2'b01, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'hFFFF_BEEF};
    vecs[11] = '{2'b01, 1'b0, 2'd2, 32'hDEAD_BEEF, 32'h0000_DEAD};

    in_valid = 0; dst = 0; ALU_res = 0; WB_en = 0; mem_read = 0;
    load_size = 0; load_signed = 0; byte_off = 0; mem_data = 0; mem_data_valid = 0;
    do_reset();

    check("rst_WB_dst", WB_dst, 0);
    check("rst_WB_en_out", WB_en_out, 0);
    check("rst_WB_value", WB_value, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_wb_busy", wb_busy, 0);

    // Non-load latency: accepted in cycle N, written in N+2, one cycle wide
    push(4'd3, 32'h0000_1234, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0000_1234);
    @(negedge clk);
    check("t1_not_yet", WB_en_out, 0);
    @(negedge clk);
    check("t1_en", WB_en_out, 1);
    check("t1_dst", WB_dst, 3);
    check("t1_value", WB_value, 32'h1234);
    @(negedge clk);
    check("t1_pulse_end", WB_en_out, 0);

    for (int i = 0; i < 12; i++) begin
      push(i[3:0], 32'hAAAA_5555, 1'b1, 1'b1, vecs[i].size, vecs[i].sgn, vecs[i].off, vecs[i].exp);
      repeat (3) @(posedge clk);
      #1;
      mem_pulse(vecs[i].data);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_drained", i), sb_q.size(), 0);
    end

    // A younger non-load must wait behind a pending load
    w0 = n_writes;
    push(4'd5, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 32'hCAFE_F00D);
    push(4'd6, 32'h66, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h66);
    check("t3_full", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_no_early_write", n_writes - w0, 0);
    check("t3_still_full", in_ready, 0);
    mem_pulse(32'hCAFE_F00D);
    @(negedge clk);
    check("t3_load_en", WB_en_out, 1);
    check("t3_load_dst", WB_dst, 5);
    check("t3_ready_back", in_ready, 1);
    @(negedge clk);
    check("t3_alu_en", WB_en_out, 1);
    check("t3_alu_dst", WB_dst, 6);
    @(negedge clk);
    check("t3_done_en", WB_en_out, 0);
    check("t3_idle", wb_busy, 0);

    // Streaming non-loads: one retire per cycle, occupancy stays at one
    w0 = n_writes;
    WB_en = 1'b1; mem_read = 1'b0; load_size = 2'b10;
    for (int k = 0; k < 10; k++) begin
      dst = k[3:0];
      ALU_res = 32'h100 + k;
      in_valid = 1'b1;
      check($sformatf("t4_ready%0d", k), in_ready, 1);
      if (k > 1) check($sformatf("t4_busy%0d", k), wb_busy, 1);
      @(posedge clk); #1;
      sb_q.push_back('{k[3:0], 32'h100 + k});
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_writes", n_writes - w0, 10);
    check("t4_drained", sb_q.size(), 0);

    // Stray data on a non-load head: still retires, flags error
    push(4'd7, 32'h77, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h77);
    mem_pulse(32'h0);
    @(negedge clk);
    check("t5a_retired", WB_en_out, 1);
    check("t5a_err", proto_err, 1);
    do_reset();
    check("t5a_err_cleared", proto_err, 0);

    // Stray data with empty buffer
    w0 = n_writes;
    mem_pulse(32'h1);
    @(negedge clk);
    check("t5_err", proto_err, 1);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", proto_err, 1);
    check("t5_no_write", n_writes - w0, 0);
    do_reset();
    check("t5_err_cleared", proto_err, 0);

    // Asynchronous reset with two loads pending
    push(4'd8, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 32'h8);
    push(4'd9, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 32'h9);
    @(negedge clk);
    check("t6_busy_before", wb_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_busy", wb_busy, 0);
    check("t6_ready", in_ready, 1);
    check("t6_en_out", WB_en_out, 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    w0 = n_writes;
    mem_pulse(32'h9999);
    @(negedge clk);
    check("t6_err", proto_err, 1);
    check("t6_no_write", n_writes - w0, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
